// File: rtl/mlp_job_arbiter.sv
// Round-robin job arbiter sharing one MLP core between R requesters; one job in flight at a time.
// Optional watchdog abort of a stuck core is enabled by defining MLP_ARB_TIMEOUT_EN.
module mlp_job_arbiter #(
  parameter int WORD_SIZE = 8,
  parameter int N         = 16,
  parameter int R         = 4,
  parameter int TIMEOUT   = 4096
) (
  input  logic                         clk,
  input  logic                         n_rst,
  input  logic [R-1:0]                 req_valid,
  output logic [R-1:0]                 req_ready,
  input  logic [R*N*WORD_SIZE-1:0]     req_data,
  output logic                         mlp_init,
  output logic [N*WORD_SIZE-1:0]       mlp_inputs,
  input  logic                         mlp_ready,
  input  logic [N*WORD_SIZE-1:0]       mlp_outputs,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [$clog2(R)-1:0]         rsp_id,
  output logic [N*WORD_SIZE-1:0]       rsp_data,
  output logic                         rsp_err,
  output logic                         busy,
  output logic [15:0]                  jobs_done
);

  localparam int VW = N * WORD_SIZE;
  localparam int IW = $clog2(R);

  if (R < 2 || TIMEOUT < 2) begin : g_bad_cfg
    $error("mlp_job_arbiter: R and TIMEOUT must both be >= 2");
  end

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t          state_q;
  logic [IW-1:0]   rr_q;
  logic [IW-1:0]   id_q;
  logic [VW-1:0]   inputs_q;
  logic [VW-1:0]   data_q;
  logic            init_q;
  logic [15:0]     jobs_q;

  logic            grant_vld;
  logic [IW-1:0]   grant;
  logic [IW:0]     cand;
  logic [VW-1:0]   grant_dat;
  logic            hs;

  // Search starts one past the last served requester; the extra bit absorbs the wrap for any R.
  always_comb begin
    grant_vld = 1'b0;
    grant     = '0;
    cand      = '0;
    for (int k = 1; k <= R; k++) begin
      cand = {1'b0, rr_q} + (IW+1)'(k);
      if (cand >= (IW+1)'(R)) cand = cand - (IW+1)'(R);
      if (!grant_vld && req_valid[cand[IW-1:0]]) begin
        grant_vld = 1'b1;
        grant     = cand[IW-1:0];
      end
    end
  end

  always_comb begin
    grant_dat = '0;
    for (int r = 0; r < R; r++) begin
      if (grant == IW'(r)) grant_dat = req_data[r*VW +: VW];
    end
  end

  assign hs        = (state_q == S_IDLE) && grant_vld;
  assign req_ready = hs ? (R'(1) << grant) : '0;

`ifdef MLP_ARB_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT);
  logic [WD_W-1:0] wdog_q;
  logic            err_q;
  assign rsp_err = err_q;
`else
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= S_IDLE;
      rr_q     <= '0;
      id_q     <= '0;
      inputs_q <= '0;
      data_q   <= '0;
      init_q   <= 1'b0;
      jobs_q   <= '0;
`ifdef MLP_ARB_TIMEOUT_EN
      wdog_q   <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      init_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (hs) begin
            inputs_q <= grant_dat;
            id_q     <= grant;
            init_q   <= 1'b1;
            state_q  <= S_ISSUE;
          end
        end
        S_ISSUE: begin
`ifdef MLP_ARB_TIMEOUT_EN
          wdog_q  <= '0;
`endif
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          // A completion on the expiry cycle still counts as a good result.
          if (mlp_ready) begin
            data_q  <= mlp_outputs;
`ifdef MLP_ARB_TIMEOUT_EN
            err_q   <= 1'b0;
`endif
            state_q <= S_RESP;
          end
`ifdef MLP_ARB_TIMEOUT_EN
          else if (wdog_q == WD_W'(TIMEOUT - 1)) begin
            data_q  <= '0;
            err_q   <= 1'b1;
            state_q <= S_RESP;
          end else begin
            wdog_q <= wdog_q + 1'b1;
          end
`endif
        end
        S_RESP: begin
          if (rsp_ready) begin
            rr_q    <= id_q;
            jobs_q  <= jobs_q + 16'd1;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mlp_init   = init_q;
  assign mlp_inputs = inputs_q;
  assign rsp_valid  = (state_q == S_RESP);
  assign rsp_id     = id_q;
  assign rsp_data   = data_q;
  assign busy       = (state_q != S_IDLE);
  assign jobs_done  = jobs_q;

endmodule

// File: tb/tb_mlp_job_arbiter.sv
// Randomized bench for mlp_job_arbiter against a job-level round-robin reference model.
// Define MLP_ARB_TIMEOUT_EN for both files to also exercise the watchdog path.
module tb_mlp_job_arbiter;
  localparam int W  = 8;
  localparam int N  = 16;
  localparam int R  = 4;
  localparam int TO = 64;
  localparam int VW = N * W;

  logic              clk = 1'b0;
  logic              n_rst;
  logic [R-1:0]      req_valid;
  logic [R-1:0]      req_ready;
  logic [R*VW-1:0]   req_data;
  logic              mlp_init;
  logic [VW-1:0]     mlp_inputs;
  logic              mlp_ready;
  logic [VW-1:0]     mlp_outputs;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [1:0]        rsp_id;
  logic [VW-1:0]     rsp_data;
  logic              rsp_err;
  logic              busy;
  logic [15:0]       jobs_done;

  logic [VW-1:0]     vec [R];
  int                checks = 0;
  int                failures = 0;
  int                rr_m = 0;
  int                jobs_m = 0;

  always #5 clk = ~clk;

  always_comb begin
    req_data = '0;
    for (int r = 0; r < R; r++) req_data[r*VW +: VW] = vec[r];
  end

  mlp_job_arbiter #(.WORD_SIZE(W), .N(N), .R(R), .TIMEOUT(TO)) dut (
    .clk(clk), .n_rst(n_rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .mlp_init(mlp_init), .mlp_inputs(mlp_inputs),
    .mlp_ready(mlp_ready), .mlp_outputs(mlp_outputs),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy), .jobs_done(jobs_done)
  );

  task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic rand_vecs();
    for (int r = 0; r < R; r++) vec[r] = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // Reference arbitration: first requester after the last served one, circularly.
  function automatic int model_grant(input logic [R-1:0] v, input int rr);
    for (int k = 1; k <= R; k++) begin
      if (v[(rr + k) % R]) return (rr + k) % R;
    end
    return -1;
  endfunction

  // One complete job seen from the host, core and consumer side; must start in IDLE at a negedge.
  task automatic run_job(input logic [R-1:0] vld, input int lat, input int bp, input bit spur,
                         input logic [VW-1:0] res, output int g);
    logic [VW-1:0] dat;
    g = model_grant(vld, rr_m);
    if (spur) begin
      req_valid   = '0;
      mlp_ready   = 1'b1;
      mlp_outputs = ~res;
      tick();
      mlp_ready = 1'b0;
      chk("idle_spur_busy", busy, 0);
    end
    req_valid = vld;
    #1;
    chk("req_ready", req_ready, R'(1) << g);
    dat = vec[g];
    tick();
    chk("mlp_init", mlp_init, 1);
    chk("mlp_inputs", mlp_inputs, dat);
    chk("issue_req_ready", req_ready, 0);
    rand_vecs();
    req_valid   = R'($urandom_range(1, (1 << R) - 1));
    mlp_ready   = spur;
    mlp_outputs = ~res;
    tick();
    mlp_ready = 1'b0;
    chk("init_pulse", mlp_init, 0);
    chk("busy", busy, 1);
    for (int i = 0; i < lat; i++) begin
      tick();
      chk("wait_rsp_valid", rsp_valid, 0);
      chk("wait_req_ready", req_ready, 0);
    end
    mlp_ready   = 1'b1;
    mlp_outputs = res;
    tick();
    mlp_ready   = 1'b0;
    mlp_outputs = {$urandom, $urandom, $urandom, $urandom};
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_id", rsp_id, g);
    chk("rsp_data", rsp_data, res);
    chk("rsp_err", rsp_err, 0);
    chk("inputs_held", mlp_inputs, dat);
    for (int i = 0; i < bp; i++) begin
      mlp_ready = 1'($urandom_range(0, 1));
      tick();
      chk("bp_rsp_valid", rsp_valid, 1);
      chk("bp_rsp_id", rsp_id, g);
      chk("bp_rsp_data", rsp_data, res);
      chk("bp_req_ready", req_ready, 0);
    end
    mlp_ready = 1'b0;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    jobs_m++;
    rr_m = g;
    chk("post_rsp_valid", rsp_valid, 0);
    chk("post_busy", busy, 0);
    chk("jobs_done", jobs_done, 16'(jobs_m));
    req_valid = '0;
  endtask

  initial begin
    int g;
    int order [5] = '{1, 2, 3, 0, 1};
    logic [VW-1:0] res;

    n_rst       = 1'b0;
    req_valid   = '0;
    mlp_ready   = 1'b0;
    mlp_outputs = '0;
    rsp_ready   = 1'b0;
    rand_vecs();
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_mlp_init", mlp_init, 0);
    chk("rst_jobs", jobs_done, 0);
    chk("rst_inputs", mlp_inputs, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_req_ready", req_ready, 0);
    tick();
    tick();
    n_rst = 1'b1;
    tick();

    // Single directed job from requester 2 with a 20-cycle core.
    rand_vecs();
    vec[2][7:0] = 8'h12;
    res = {$urandom, $urandom, $urandom, $urandom};
    res[7:0] = 8'h34;
    run_job(4'b0100, 20, 0, 1'b0, res, g);
    chk("single_id", g, 2);

    // Asynchronous reset while a job waits on the core.
    rand_vecs();
    req_valid = 4'b0001;
    tick();
    req_valid = '0;
    tick();
    tick();
    #2;
    n_rst = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_rsp_valid", rsp_valid, 0);
    chk("arst_mlp_init", mlp_init, 0);
    chk("arst_jobs", jobs_done, 0);
    chk("arst_inputs", mlp_inputs, 0);
    @(negedge clk);
    n_rst  = 1'b1;
    rr_m   = 0;
    jobs_m = 0;
    tick();

    // All requesters busy: strict rotation starting after pointer 0.
    for (int j = 0; j < 5; j++) begin
      rand_vecs();
      run_job(4'b1111, $urandom_range(0, 5), 0, 1'b0, {$urandom, $urandom, $urandom, $urandom}, g);
      chk("rr_order", g, order[j]);
    end

    // Long consumer backpressure with spurious core pulses.
    rand_vecs();
    run_job(4'b0110, 3, 10, 1'b1, {$urandom, $urandom, $urandom, $urandom}, g);

`ifdef MLP_ARB_TIMEOUT_EN
    rand_vecs();
    req_valid = 4'b1000;
    g = model_grant(req_valid, rr_m);
    tick();
    req_valid = '0;
    tick();
    for (int i = 0; i < TO - 1; i++) begin
      tick();
      chk("to_wait", rsp_valid, 0);
    end
    tick();
    chk("to_rsp_valid", rsp_valid, 1);
    chk("to_rsp_err", rsp_err, 1);
    chk("to_rsp_data", rsp_data, 0);
    chk("to_rsp_id", rsp_id, g);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    jobs_m++;
    rr_m = g;
    chk("to_jobs", jobs_done, 16'(jobs_m));
    rand_vecs();
    run_job(4'b0011, TO - 1, 1, 1'b0, {$urandom, $urandom, $urandom, $urandom}, g);
    rand_vecs();
    run_job(4'b1111, 2, 0, 1'b0, {$urandom, $urandom, $urandom, $urandom}, g);
`endif

    for (int j = 0; j < 25; j++) begin
      rand_vecs();
      run_job(R'($urandom_range(1, (1 << R) - 1)), $urandom_range(0, 8), $urandom_range(0, 4),
              1'($urandom_range(0, 1)), {$urandom, $urandom, $urandom, $urandom}, g);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
